axi4_lite_mem: RTL and testbench
================================

Name: axi4_lite_mem

Overview:
- AXI4-Lite slave memory: a small register-file RAM reached through the team's `axi4_lite` interface (slave modport, port name `axi4_s`).
- Used as a bus-attached scratch memory and as a reference slave for interconnect and bench bring-up.
- Word-addressed; single-beat reads and writes; reset clears the entire contents.

Parameters:
- DATA_WIDTH, 32, data bus width and memory word width (taken from the interface).
- ADDR_WIDTH, 32, address bus width (taken from the interface).
- MEM_DEPTH, 16, number of words; must be a power of two ≥ 2.

Ports:
All ports are carried by interface port `axi4_s` (axi4_lite slave modport).
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset.
- awaddr  in  ADDR_WIDTH  write word index.
- awvalid  in  1
- awready  out  1
- awprot  in  3  ignored.
- wdata  in  DATA_WIDTH
- wstrb  in  DATA_WIDTH/8  ignored.
- wvalid  in  1
- wready  out  1
- bresp  out  2
- bvalid  out  1
- bready  in  1
- araddr  in  ADDR_WIDTH  read word index.
- arvalid  in  1
- arready  out  1
- arprot  in  3  ignored.
- rdata  out  DATA_WIDTH
- rresp  out  2
- rvalid  out  1
- rready  in  1

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Storage: array `memory[MEM_DEPTH]` of DATA_WIDTH flops.
  - rst_n low clears every word to 0 asynchronously.
  - All outputs are 0 during reset.
- Addressing: awaddr/araddr are word indices, not byte addresses.
  - An index < MEM_DEPTH is in range; anything larger is out of range.
- Write channel:
  - awready = wready = 1 whenever out of reset, with no stall.
  - A write is accepted on any rising edge where awvalid && wvalid.
  - AW or W presented alone is not accepted and is not buffered.
  - In range: memory[awaddr] <= wdata (full word; wstrb ignored); bresp=OKAY (2'b00).
  - Out of range: memory is unchanged; bresp=SLVERR (2'b10).
  - bvalid is set the cycle after acceptance and held until bready.
  - Further writes are still accepted while bvalid is pending. Each new acceptance refreshes bresp, and bvalid remains 1.
  - Back-to-back writes at one per cycle are supported.
- Read channel:
  - arready = !rvalid || rready.
  - A read is accepted on the edge where arvalid && arready.
  - 1-cycle latency: the next cycle has rvalid=1 and rdata = memory[araddr].
  - In range: rresp=OKAY. Out of range: rdata=0, rresp=SLVERR.
  - rdata/rresp are held stable while rvalid && !rready.
  - rvalid clears on rready when no new read is accepted the same edge.
  - With rready held 1, back-to-back reads stream one per cycle.
- Simultaneous write and read to the same index in one edge: the read returns the old (pre-write) data.
- Reset mid-transaction:
  - bvalid and rvalid drop immediately.
  - Memory is cleared and pending responses are discarded.
- Unused inputs (awprot, arprot, wstrb): no effect.

Decomposition:
- Package `axi4_lite_pkg`: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, and typedef resp_t.
- Sub-module `axi4_lite_mem_array`: the MEM_DEPTH×DATA_WIDTH register file.
  - One write port with enable, one synchronous read port, async clear on rst_n.
  - Channel handshake logic stays in the top level.

Test Plan:
- Reset, then read words 0..3 -> each returns rdata=32'h0, rresp=OKAY, rvalid one cycle after arvalid.
- Staggered writes 32'h5555_5555 to indices 1,2,3 (idle cycle between each) -> reads of 1..3 return 32'h5555_5555; each write yields a bvalid with bresp=OKAY.
- Reset after those writes, then read 1..3 -> all return 32'h0 (memory cleared).
- Back-to-back writes with bready=0: idx1=AAAA_AAAA, idx2=5555_5555, idx3=F0F0_F0F0.
  - Then back-to-back reads 0,1,2,3 with rready=1.
  - Required: consecutive rvalid cycles returning 0, AAAA_AAAA, 5555_5555, F0F0_F0F0.
  - bvalid held high until bready is raised.
- Write DEADBEEF to index MEM_DEPTH -> bresp=SLVERR and no word changes; read index MEM_DEPTH -> rdata=0, rresp=SLVERR.
- Read with rready=0 for 3 cycles -> rvalid and rdata held stable, arready=0; raising rready completes the beat and restores arready=1.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and their type.
package axi4_lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite.sv
// AXI4-Lite bus bundle with master and slave views; clock and reset travel with the bus.
interface axi4_lite #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic clk,
   input logic rst_n
);

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [2:0]              awprot;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [2:0]              arprot;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  clk, rst_n,
      input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
      input  araddr, arvalid, arprot, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      input  clk, rst_n,
      output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
      output araddr, arvalid, arprot, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi4_lite_mem_array.sv
// Register-file storage: one write port, one registered read port, async clear.
module axi4_lite_mem_array
   import axi4_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 16,
   localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Storage words; reset wipes the whole array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en) begin
         mem_r[wr_idx] <= wr_data;
      end
   end

   // Read register samples pre-write contents and holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r <= '0;
      end else if (rd_en) begin
         rd_data_r <= mem_r[rd_idx];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/axi4_lite_mem.sv
// AXI4-Lite slave scratch memory, word-indexed, single-beat, cleared on reset.
module axi4_lite_mem
   import axi4_lite_pkg::*;
#(
   parameter int MEM_DEPTH = 16
) (
   axi4_lite.slave axi4_s
);

   localparam int DATA_WIDTH = $bits(axi4_s.wdata);
   localparam int ADDR_WIDTH = $bits(axi4_s.awaddr);
   localparam int IDX_W      = $clog2(MEM_DEPTH);

   logic                  aw_accept_s;
   logic                  ar_accept_s;
   logic                  arready_s;
   logic                  wr_in_range_s;
   logic                  rd_in_range_s;
   logic [DATA_WIDTH-1:0] rd_data_s;
   logic                  bvalid_r;
   resp_t                 bresp_r;
   logic                  rvalid_r;
   resp_t                 rresp_r;
   logic                  rd_err_r;
   logic                  unused_s;

   // Handshake decode; AW and W are only taken together.
   always_comb begin
      aw_accept_s   = axi4_s.awvalid && axi4_s.wvalid;
      wr_in_range_s = (axi4_s.awaddr < ADDR_WIDTH'(MEM_DEPTH));
      rd_in_range_s = (axi4_s.araddr < ADDR_WIDTH'(MEM_DEPTH));
      arready_s     = axi4_s.rst_n && (!rvalid_r || axi4_s.rready);
      ar_accept_s   = axi4_s.arvalid && arready_s;
   end

   axi4_lite_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_array (
      .clk     (axi4_s.clk),
      .rst_n   (axi4_s.rst_n),
      .wr_en   (aw_accept_s && wr_in_range_s),
      .wr_idx  (axi4_s.awaddr[IDX_W-1:0]),
      .wr_data (axi4_s.wdata),
      .rd_en   (ar_accept_s && rd_in_range_s),
      .rd_idx  (axi4_s.araddr[IDX_W-1:0]),
      .rd_data (rd_data_s)
   );

   // Response channels; a new write refreshes bresp even while bvalid is pending.
   always_ff @(posedge axi4_s.clk or negedge axi4_s.rst_n) begin
      if (!axi4_s.rst_n) begin
         bvalid_r <= 1'b0;
         bresp_r  <= RESP_OKAY;
         rvalid_r <= 1'b0;
         rresp_r  <= RESP_OKAY;
         rd_err_r <= 1'b0;
      end else begin
         if (aw_accept_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
         end else if (axi4_s.bready) begin
            bvalid_r <= 1'b0;
         end
         if (ar_accept_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
            rd_err_r <= !rd_in_range_s;
         end else if (axi4_s.rready) begin
            rvalid_r <= 1'b0;
         end
      end
   end

   assign axi4_s.awready = axi4_s.rst_n;
   assign axi4_s.wready  = axi4_s.rst_n;
   assign axi4_s.arready = arready_s;
   assign axi4_s.bvalid  = bvalid_r;
   assign axi4_s.bresp   = bresp_r;
   assign axi4_s.rvalid  = rvalid_r;
   assign axi4_s.rresp   = rresp_r;
   assign axi4_s.rdata   = rd_err_r ? '0 : rd_data_s;

   assign unused_s = ^{1'b0, axi4_s.awprot, axi4_s.arprot, axi4_s.wstrb};

endmodule

// File: tb/tb_axi4_lite_mem.sv
// Scoreboard bench for axi4_lite_mem: expectations queued at acceptance, checked on response handshakes.
module tb_axi4_lite_mem;
   import axi4_lite_pkg::*;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   lat_req = 0;
   int   lat_done = 0;

   logic [31:0] model [DEPTH];
   rexp_t       rexp_q [$];
   logic [1:0]  bexp_q [$];
   rexp_t       re_v;
   logic [31:0] held_v;

   axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus (.clk(clk), .rst_n(rst_n));

   axi4_lite_mem #(.MEM_DEPTH(DEPTH)) dut (.axi4_s(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic rexp_t read_exp(input logic [31:0] idx);
      rexp_t e;
      if (idx < 32'(DEPTH)) begin
         e.data = model[idx[3:0]];
         e.resp = RESP_OKAY;
      end else begin
         e.data = 32'h0;
         e.resp = RESP_SLVERR;
      end
      return e;
   endfunction

   task automatic do_write(input logic [31:0] idx, input logic [31:0] data);
      bus.awaddr  = idx;
      bus.wdata   = data;
      bus.wstrb   = 4'($urandom_range(0, 15));
      bus.awprot  = 3'($urandom_range(0, 7));
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      @(posedge clk);
      if (idx < 32'(DEPTH)) begin
         model[idx[3:0]] = data;
         bexp_q.push_back(RESP_OKAY);
      end else begin
         bexp_q.push_back(RESP_SLVERR);
      end
      #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] idx);
      int n = 0;
      bus.araddr  = idx;
      bus.arprot  = 3'($urandom_range(0, 7));
      bus.arvalid = 1'b1;
      @(negedge clk);
      while (!bus.arready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!bus.arready) begin
         chk("ar_timeout", 64'(bus.arready), 64'h1);
         bus.arvalid = 1'b0;
      end else begin
         rexp_q.push_back(read_exp(idx));
         @(posedge clk);
         lat_req++;
         #1;
         bus.arvalid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Response monitor: latency, read data and write response checks.
   always @(negedge clk) begin
      if (rst_n) begin
         if (lat_req != lat_done) begin
            chk("r_latency", 64'(bus.rvalid), 64'h1);
            lat_done = lat_req;
         end
         if (bus.rvalid && bus.rready) begin
            if (rexp_q.size() == 0) begin
               chk("r_unexpected", 64'(bus.rvalid), 64'h0);
            end else begin
               re_v = rexp_q.pop_front();
               chk("rdata", 64'(bus.rdata), 64'(re_v.data));
               chk("rresp", 64'(bus.rresp), 64'(re_v.resp));
            end
         end
         if (bus.bvalid && bus.bready) begin
            if (bexp_q.size() == 0) begin
               chk("b_unexpected", 64'(bus.bvalid), 64'h0);
            end else begin
               chk("bresp", 64'(bus.bresp), 64'(bexp_q[bexp_q.size()-1]));
               bexp_q.delete();
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.awprot = 3'h0;
      bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
      bus.bready = 1'b1; bus.araddr = 32'h0; bus.arvalid = 1'b0;
      bus.arprot = 3'h0; bus.rready = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rst_awready", 64'(bus.awready), 64'h0);
      chk("rst_wready",  64'(bus.wready),  64'h0);
      chk("rst_arready", 64'(bus.arready), 64'h0);
      chk("rst_bvalid",  64'(bus.bvalid),  64'h0);
      chk("rst_rvalid",  64'(bus.rvalid),  64'h0);
      chk("rst_rdata",   64'(bus.rdata),   64'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("awready_up", 64'(bus.awready), 64'h1);

      // Fresh memory reads back zero
      for (int i = 0; i < 4; i++) do_read(32'(i));
      idle(2);

      // Staggered writes then readback
      for (int i = 1; i < 4; i++) begin
         do_write(32'(i), 32'h5555_5555);
         idle(1);
      end
      for (int i = 1; i < 4; i++) do_read(32'(i));
      idle(2);

      // Reset with both responses pending
      bus.bready = 1'b0;
      bus.rready = 1'b0;
      do_write(32'd4, 32'h1357_9BDF);
      do_read(32'd1);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bvalid", 64'(bus.bvalid), 64'h0);
      chk("mid_rst_rvalid", 64'(bus.rvalid), 64'h0);
      chk("mid_rst_rdata",  64'(bus.rdata),  64'h0);
      rexp_q.delete();
      bexp_q.delete();
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      bus.bready = 1'b1;
      bus.rready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      for (int i = 1; i < 5; i++) do_read(32'(i));
      idle(2);

      // Back-to-back writes with bready low, then streaming reads
      bus.bready = 1'b0;
      do_write(32'd1, 32'hAAAA_AAAA);
      do_write(32'd2, 32'h5555_5555);
      do_write(32'd3, 32'hF0F0_F0F0);
      idle(3);
      chk("b_hold_valid", 64'(bus.bvalid), 64'h1);
      chk("b_hold_resp",  64'(bus.bresp),  64'(RESP_OKAY));
      for (int i = 0; i < 4; i++) do_read(32'(i));
      idle(2);
      chk("b_still_held", 64'(bus.bvalid), 64'h1);
      bus.bready = 1'b1;
      idle(1);
      #4;
      chk("b_released", 64'(bus.bvalid), 64'h0);

      // Out-of-range write must not touch memory; out-of-range reads error
      do_write(32'd16, 32'hDEAD_BEEF);
      idle(2);
      do_write(32'd5, 32'hC3C3_3C3C);
      do_write(32'hFFFF_FFF0, 32'h0BAD_0BAD);
      idle(2);
      for (int i = 0; i < DEPTH; i++) do_read(32'(i));
      do_read(32'd16);
      do_read(32'h8000_0001);
      idle(2);

      // Same-edge write and read of one index returns old data
      bus.awaddr = 32'd2; bus.wdata = 32'h1234_5678;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      bus.araddr = 32'd2; bus.arvalid = 1'b1;
      @(negedge clk);
      rexp_q.push_back(read_exp(32'd2));
      @(posedge clk);
      model[2] = 32'h1234_5678;
      bexp_q.push_back(RESP_OKAY);
      lat_req++;
      #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      do_read(32'd2);
      idle(2);

      // Read stall: rvalid/rdata held, arready low until rready
      bus.rready = 1'b0;
      do_read(32'd5);
      held_v = bus.rdata;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_rvalid",  64'(bus.rvalid),  64'h1);
         chk("stall_rdata",   64'(bus.rdata),   64'(model[5]));
         chk("stall_stable",  64'(bus.rdata),   64'(held_v));
         chk("stall_arready", 64'(bus.arready), 64'h0);
      end
      @(posedge clk);
      #1;
      bus.rready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_done_arready", 64'(bus.arready), 64'h1);
      chk("stall_done_rvalid",  64'(bus.rvalid),  64'h0);

      idle(3);
      chk("rq_empty", 64'(rexp_q.size()), 64'h0);
      chk("bq_empty", 64'(bexp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
